// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch/jump redirect flushes and
// multiply/divide occupancy, plus a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_mdu_start,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (MDU_LATENCY < 1) ? 1 : $clog2(MDU_LATENCY + 1);
  localparam logic [DW-1:0] MDU_LOAD = DW'(MDU_LATENCY);
  localparam logic [DW-1:0] ONE      = DW'(1);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t           state_reg, state_next;
  logic [DW-1:0]    mdu_cnt_reg, mdu_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic             load_use;

  // $0 is hard-wired, so a load targeting it can never feed a dependent instruction.
  assign load_use = idex_memread && (idex_rt != 5'd0) &&
                    ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg     <= RUN;
      mdu_cnt_reg   <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mdu_cnt_reg   <= mdu_cnt_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  always_comb begin
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_bubble    = 1'b0;
    state_next     = state_reg;
    mdu_cnt_next   = mdu_cnt_reg;
    stall_cnt_next = stall_cnt_reg;

    // The MDU keeps running regardless of redirects, so its tracking is independent.
    case (state_reg)
      RUN: begin
        if (!ex_redirect && !load_use && id_mdu_start) begin
          state_next   = MDU_WAIT;
          mdu_cnt_next = MDU_LOAD;
        end
      end
      MDU_WAIT: begin
        mdu_cnt_next = mdu_cnt_reg - ONE;
        if (mdu_cnt_reg <= ONE) begin
          state_next   = RUN;
          mdu_cnt_next = '0;
        end
      end
      default: begin
        state_next   = RUN;
        mdu_cnt_next = '0;
      end
    endcase

    if (RESET || ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state_reg == MDU_WAIT || load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end

    if (!pc_write && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_next = stall_cnt_reg + CNT_W'(1);
    end
  end

  assign mdu_busy  = (state_reg == MDU_WAIT);
  assign stall_cnt = stall_cnt_reg;

endmodule
